// File: rtl/seg7_bcd_feeder_if.sv
// Bus bundle for seg7_bcd_feeder.
// Carries the CPU-side slave cycle (strobe/rw/addr/d_in -> d_out) and the
// display-side master write (m_strobe/m_rw/m_addr/m_data).
//   slave  : the feeder's view (samples the CPU cycle, drives read data and master write)
//   master : the system's view (CPU drives the cycle, display driver observes the write)
interface seg7_bcd_feeder_if;
  logic        strobe;
  logic        rw;
  logic [31:0] addr;
  logic [31:0] d_in;
  logic [31:0] d_out;
  logic        m_strobe;
  logic        m_rw;
  logic [31:0] m_addr;
  logic [31:0] m_data;

  modport slave (
    input  strobe, rw, addr, d_in,
    output d_out, m_strobe, m_rw, m_addr, m_data
  );

  modport master (
    output strobe, rw, addr, d_in,
    input  d_out, m_strobe, m_rw, m_addr, m_data
  );
endinterface

// File: rtl/seg7_bcd_feeder.sv
// seg7_bcd_feeder: bus-mapped binary-to-BCD converter feeding the 7-segment
// display driver. A write to BASE+0 starts a sequential double-dabble
// conversion (one bit per cycle); the packed BCD result is then written once
// to SEG_BASE on the master side.
// Ports:
//   clk     : rising-edge clock
//   reset_n : synchronous active-low reset
//   bus     : seg7_bcd_feeder_if.slave (CPU slave cycle + display master write)
// Build option: define SEG7_BCD_OVF_EN to report operands above 9999 (or with
// nonzero upper write bits) as 0xEEEE and set the ovf status bit.
module seg7_bcd_feeder #(
  parameter logic [31:0] BASE     = 32'h20,
  parameter logic [31:0] SEG_BASE = 32'h10,
  parameter int unsigned BIN_BITS = 14
) (
  input  logic                  clk,
  input  logic                  reset_n,
  seg7_bcd_feeder_if.slave      bus
);

  localparam int unsigned BCD_BITS  = 20;
  localparam int unsigned DIGITS    = BCD_BITS / 4;
  localparam int unsigned CNT_W     = $clog2(BIN_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_BITS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_CONV, ST_WRITE} state_e;

  state_e                state_q;
  logic [BCD_BITS-1:0]   bcd_q;
  logic [BIN_BITS-1:0]   bin_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  oor_q;
  logic                  pend_q;
  logic [BIN_BITS-1:0]   pend_op_q;
  logic                  pend_oor_q;
  logic                  drop_q;
  logic                  ovf_q;
  logic [31:0]           d_out_q;
  logic                  m_strobe_q;
  logic [31:0]           m_data_q;

  logic                  sel_c;
  logic                  wr_c;
  logic                  rd_c;
  logic [BIN_BITS-1:0]   op_c;
  logic                  op_oor_c;
  logic [BCD_BITS-1:0]   bcd_adj_c;
  logic [BCD_BITS-1:0]   bcd_nx_c;
  logic [BIN_BITS-1:0]   bin_nx_c;
  logic                  ovf_c;
  logic [31:0]           res_c;
  logic [3:0]            status_c;

  // Slave decode: BASE+0 is the operand, BASE+1 is status (writes ignored).
  assign sel_c    = bus.strobe && (bus.addr[31:1] == BASE[31:1]);
  assign wr_c     = sel_c && bus.rw && !bus.addr[0];
  assign rd_c     = sel_c && !bus.rw;
  assign op_c     = bus.d_in[BIN_BITS-1:0];
  assign op_oor_c = |bus.d_in[31:BIN_BITS];
  assign status_c = {drop_q, ovf_q, pend_q, state_q != ST_IDLE};

  // Double-dabble step: add 3 to each digit >= 5, then shift {bcd,bin} left.
  always_comb begin
    bcd_adj_c = bcd_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj_c[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  assign bcd_nx_c = {bcd_adj_c[BCD_BITS-2:0], bin_q[BIN_BITS-1]};
  assign bin_nx_c = {bin_q[BIN_BITS-2:0], 1'b0};

  // Final result; the fifth digit is nonzero exactly when the operand exceeds 9999.
`ifdef SEG7_BCD_OVF_EN
  assign ovf_c = (|bcd_nx_c[BCD_BITS-1:16]) || oor_q;
  assign res_c = ovf_c ? 32'h0000_EEEE : {16'h0, bcd_nx_c[15:0]};
`else
  assign ovf_c = 1'b0;
  assign res_c = {16'h0, bcd_nx_c[15:0]};
`endif

  // Bits that only matter in the overflow build, or are shifted out.
  logic unused_c;
  assign unused_c = ^{bcd_adj_c[BCD_BITS-1], bcd_nx_c[BCD_BITS-1:16], oor_q};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      bcd_q      <= '0;
      bin_q      <= '0;
      cnt_q      <= '0;
      oor_q      <= 1'b0;
      pend_q     <= 1'b0;
      pend_op_q  <= '0;
      pend_oor_q <= 1'b0;
      drop_q     <= 1'b0;
      ovf_q      <= 1'b0;
      d_out_q    <= '0;
      m_strobe_q <= 1'b0;
      m_data_q   <= '0;
    end else begin
      m_strobe_q <= 1'b0;

      // Reads sample pre-edge state; a status read clears drop.
      if (rd_c) begin
        d_out_q <= bus.addr[0] ? {28'h0, status_c} : m_data_q;
        if (bus.addr[0]) drop_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (wr_c) begin
            bcd_q   <= '0;
            bin_q   <= op_c;
            oor_q   <= op_oor_c;
            cnt_q   <= '0;
            state_q <= ST_CONV;
          end
        end

        ST_CONV: begin
          bcd_q <= bcd_nx_c;
          bin_q <= bin_nx_c;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_ITER) begin
            state_q    <= ST_WRITE;
            m_strobe_q <= 1'b1;
            m_data_q   <= res_c;
            ovf_q      <= ovf_c;
          end
          // One-deep slot, newest wins; overwriting an unserved operand is a drop.
          if (wr_c) begin
            if (pend_q) drop_q <= 1'b1;
            pend_q     <= 1'b1;
            pend_op_q  <= op_c;
            pend_oor_q <= op_oor_c;
          end
        end

        ST_WRITE: begin
          // A fresh write beats the pending slot, discarding it.
          if (wr_c) begin
            if (pend_q) drop_q <= 1'b1;
            pend_q  <= 1'b0;
            bcd_q   <= '0;
            bin_q   <= op_c;
            oor_q   <= op_oor_c;
            cnt_q   <= '0;
            state_q <= ST_CONV;
          end else if (pend_q) begin
            pend_q  <= 1'b0;
            bcd_q   <= '0;
            bin_q   <= pend_op_q;
            oor_q   <= pend_oor_q;
            cnt_q   <= '0;
            state_q <= ST_CONV;
          end else begin
            state_q <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.d_out    = d_out_q;
  assign bus.m_strobe = m_strobe_q;
  assign bus.m_rw     = m_strobe_q;
  assign bus.m_addr   = SEG_BASE;
  assign bus.m_data   = m_data_q;

endmodule
